// File: rtl/mod_pc_gen.sv
// Fetch PC generator: prioritised redirect arbitration, sequential advance, optional HALT (PC_HALT_ON_ZERO_EN).
// Latency: redirect or handshake updates pc_o one cycle later; fetch_valid_o is combinational on redir_valid_i.
// Backpressure: fetch_ready_i low or stall_i high holds the PC; redirects are accepted regardless.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_RESET_ADDR
`define PC_RESET_ADDR 32'h8000_0000
`endif

module mod_pc_gen #(
  parameter int              XLEN         = `XLEN,
  parameter logic [XLEN-1:0] RESET_ADDR   = `PC_RESET_ADDR,
  parameter int              NUM_REDIRECT = 3,
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         stall_i,
  input  logic [NUM_REDIRECT-1:0]      redir_valid_i,
  input  logic [NUM_REDIRECT*XLEN-1:0] redir_pc_i,
  output logic [NUM_REDIRECT-1:0]      redir_ack_o,
  output logic [XLEN-1:0]              pc_o,
  output logic                         fetch_valid_o,
  input  logic                         fetch_ready_i,
  output logic                         misalign_o,
  output logic                         halted_o
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;
  localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);

  state_e                  state_q, state_d;
  logic [XLEN-1:0]         pc_q, pc_d;
  logic                    mis_q, mis_d;
  logic                    redir_any;
  logic [NUM_REDIRECT-1:0] win_oh;
  logic [XLEN-1:0]         win_pc;
  logic [XLEN-1:0]         tgt_aligned;
  logic                    tgt_mis;
  logic [XLEN-1:0]         pc_inc;

  // Descending scan so the lowest-index requester is the last one written.
  always_comb begin
    win_oh = '0;
    win_pc = '0;
    for (int k = NUM_REDIRECT - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        win_oh    = '0;
        win_oh[k] = 1'b1;
        win_pc    = redir_pc_i[k*XLEN +: XLEN];
      end
    end
  end

  assign redir_any   = |redir_valid_i;
  assign tgt_aligned = win_pc & ALIGN_MASK;
  assign tgt_mis     = |(win_pc & ~ALIGN_MASK);
  assign pc_inc      = pc_q + INC_V;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mis_d         = 1'b0;
    fetch_valid_o = 1'b0;
    redir_ack_o   = '0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redir_any) begin
          // Accept cycle squashes the stale PC; stall and ready are irrelevant here.
          redir_ack_o = win_oh;
          pc_d        = tgt_aligned;
          mis_d       = tgt_mis;
`ifdef PC_HALT_ON_ZERO_EN
          if (tgt_aligned == '0) state_d = HALT;
`endif
        end else begin
          fetch_valid_o = 1'b1;
          if (fetch_ready_i && !stall_i) begin
            pc_d = pc_inc;
`ifdef PC_HALT_ON_ZERO_EN
            if (pc_inc == '0) state_d = HALT;
`endif
          end
        end
      end
      HALT:    pc_d = '0;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      pc_q    <= RESET_ADDR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_o       = pc_q;
  assign misalign_o = mis_q;

`ifdef PC_HALT_ON_ZERO_EN
  assign halted_o = (state_q == HALT);
`else
  assign halted_o = 1'b0;
`endif

endmodule

// File: tb/tb_mod_pc_gen.sv
// Bench for mod_pc_gen: table of per-cycle vectors through a scoreboard, plus an async reset sequence.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_mod_pc_gen;

`ifdef PC_HALT_ON_ZERO_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam logic [31:0] RST = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [2:0]  rv;
  logic [95:0] rpc;
  logic [2:0]  ack;
  logic [31:0] pc;
  logic        vld;
  logic        rdy;
  logic        mis;
  logic        halt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_pc_gen #(
    .XLEN(32), .RESET_ADDR(RST), .NUM_REDIRECT(3), .INC(4), .ALIGN_BITS(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
    .redir_valid_i(rv), .redir_pc_i(rpc), .redir_ack_o(ack),
    .pc_o(pc), .fetch_valid_o(vld), .fetch_ready_i(rdy),
    .misalign_o(mis), .halted_o(halt)
  );

  typedef struct {
    logic        r;
    logic        st;
    logic        rd;
    logic [2:0]  rv;
    logic [31:0] p0, p1, p2;
    logic [31:0] epc;
    logic        ev;
    logic [2:0]  eack;
    logic        emis;
    logic        eh;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic r, logic st, logic rd, logic [2:0] v,
                              logic [31:0] p0, logic [31:0] p1, logic [31:0] p2,
                              logic [31:0] epc, logic ev, logic [2:0] eack,
                              logic emis, logic eh);
    vec_t t;
    t.r = r; t.st = st; t.rd = rd; t.rv = v;
    t.p0 = p0; t.p1 = p1; t.p2 = p2;
    t.epc = epc; t.ev = ev; t.eack = eack; t.emis = emis; t.eh = eh;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.r;
    stall = v.st;
    rdy   = v.rd;
    rv    = v.rv;
    rpc   = {v.p2, v.p1, v.p0};
    sb.push_back(v);
  endtask

  task automatic check_out(input int idx);
    vec_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", idx, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("pc", idx, pc, e.epc);
      chk("valid", idx, {31'd0, vld}, {31'd0, e.ev});
      chk("ack", idx, {29'd0, ack}, {29'd0, e.eack});
      chk("misalign", idx, {31'd0, mis}, {31'd0, e.emis});
      chk("halted", idx, {31'd0, halt}, {31'd0, e.eh});
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; rdy = 1'b0; rv = '0; rpc = '0;

    // r st rd rv p0 p1 p2 | pc valid ack mis halt
    tbl.push_back(mk(0,0,1,3'b111, 32'h10, 32'h20, 32'h30, RST, 0, 3'b000, 0, 0));
    tbl.push_back(mk(1,0,1,3'b000, 0, 0, 0, RST,            0, 3'b000, 0, 0));
    tbl.push_back(mk(1,0,1,3'b000, 0, 0, 0, RST,            1, 3'b000, 0, 0));
    tbl.push_back(mk(1,0,1,3'b000, 0, 0, 0, 32'h8000_0004,  1, 3'b000, 0, 0));
    tbl.push_back(mk(1,0,1,3'b000, 0, 0, 0, 32'h8000_0008,  1, 3'b000, 0, 0));
    tbl.push_back(mk(1,0,1,3'b000, 0, 0, 0, 32'h8000_000C,  1, 3'b000, 0, 0));
    tbl.push_back(mk(1,1,1,3'b100, 0, 0, 32'h8000_0100, 32'h8000_0010, 0, 3'b100, 0, 0));
    tbl.push_back(mk(1,1,1,3'b000, 0, 0, 0, 32'h8000_0100,  1, 3'b000, 0, 0));
    tbl.push_back(mk(1,1,1,3'b000, 0, 0, 0, 32'h8000_0100,  1, 3'b000, 0, 0));
    tbl.push_back(mk(1,0,0,3'b000, 0, 0, 0, 32'h8000_0100,  1, 3'b000, 0, 0));
    tbl.push_back(mk(1,0,1,3'b011, 32'h200, 32'h300, 0, 32'h8000_0100, 0, 3'b001, 0, 0));
    tbl.push_back(mk(1,0,1,3'b010, 0, 32'h300, 0, 32'h200,  0, 3'b010, 0, 0));
    tbl.push_back(mk(1,0,1,3'b000, 0, 0, 0, 32'h300,        1, 3'b000, 0, 0));
    tbl.push_back(mk(1,0,1,3'b001, 32'h8000_0102, 0, 0, 32'h304, 0, 3'b001, 0, 0));
    tbl.push_back(mk(1,0,0,3'b000, 0, 0, 0, 32'h8000_0100,  1, 3'b000, 1, 0));
    tbl.push_back(mk(1,0,0,3'b000, 0, 0, 0, 32'h8000_0100,  1, 3'b000, 0, 0));
    tbl.push_back(mk(1,0,1,3'b001, 32'hFFFF_FFFC, 0, 0, 32'h8000_0100, 0, 3'b001, 0, 0));
    tbl.push_back(mk(1,0,1,3'b000, 0, 0, 0, 32'hFFFF_FFFC,  1, 3'b000, 0, 0));
    tbl.push_back(mk(1,0,1,3'b000, 0, 0, 0, 32'h0, !HALT_EN, 3'b000, 0, HALT_EN));
    tbl.push_back(mk(1,0,1,3'b001, 32'h40, 0, 0, HALT_EN ? 32'h0 : 32'h4, 0,
                     HALT_EN ? 3'b000 : 3'b001, 0, HALT_EN));
    tbl.push_back(mk(1,0,1,3'b000, 0, 0, 0, HALT_EN ? 32'h0 : 32'h40, !HALT_EN, 3'b000, 0, HALT_EN));

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check_out(i);
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", 99, sb.size(), 32'd0);

    // Asynchronous reset mid-cycle: outputs must react before any clock edge.
    rv = '0; rdy = 1'b1; stall = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", 100, pc, RST);
    chk("async_rst_valid", 100, {31'd0, vld}, 32'd0);
    chk("async_rst_halted", 100, {31'd0, halt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_valid", 101, {31'd0, vld}, 32'd0);
    chk("boot_pc", 101, pc, RST);
    @(posedge clk); #1;
    @(negedge clk);
    chk("run_valid", 102, {31'd0, vld}, 32'd1);
    chk("run_pc", 102, pc, RST);
    @(posedge clk); #1;
    chk("run_advance", 103, pc, RST + 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
